// File: rtl/dcram_arb_pkg.sv
// Shared types for the data-cache RAM port arbiter: fill FSM states, grant
// sources and bank-select encodings.
package dcram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_FILL = 2'd1,
    SRC_STB  = 2'd2,
    SRC_PIPE = 2'd3
  } grant_src_e;

  localparam logic [1:0] BANK_NONE = 2'b00;
  localparam logic [1:0] BANK_LO   = 2'b01;
  localparam logic [1:0] BANK_HI   = 2'b10;
  localparam logic [1:0] BANK_BOTH = 2'b11;

  // A 32-bit store lands in the high word bank when byte address bit 2 is set.
  function automatic logic [1:0] store_bank(input logic addr_bit2);
    return addr_bit2 ? BANK_HI : BANK_LO;
  endfunction

endpackage

// File: rtl/dcram_arb_if.sv
// Requester and RAM-command bundle between the cache front end and dcram_arb.
interface dcram_arb_if #(parameter int ADDR_W = 14);

  logic              pipe_req;
  logic [ADDR_W-1:0] pipe_addr;
  logic              pipe_gnt;

  logic              stb_req;
  logic [ADDR_W-1:0] stb_addr;
  logic [31:0]       stb_data;
  logic [3:0]        stb_be;
  logic              stb_gnt;

  logic              fill_start;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_valid;
  logic [63:0]       fill_data;
  logic              fill_busy;
  logic              fill_done;

  logic [ADDR_W-1:0] dc_addr;
  logic [1:0]        dc_bank_sel;
  logic [3:0]        dc_we;
  logic [63:0]       dc_data;
  logic              dc_bypass;

  modport master (
    output pipe_req, pipe_addr,
    output stb_req, stb_addr, stb_data, stb_be,
    output fill_start, fill_addr, fill_valid, fill_data,
    input  pipe_gnt, stb_gnt, fill_busy, fill_done,
    input  dc_addr, dc_bank_sel, dc_we, dc_data, dc_bypass
  );

  modport slave (
    input  pipe_req, pipe_addr,
    input  stb_req, stb_addr, stb_data, stb_be,
    input  fill_start, fill_addr, fill_valid, fill_data,
    output pipe_gnt, stb_gnt, fill_busy, fill_done,
    output dc_addr, dc_bank_sel, dc_we, dc_data, dc_bypass
  );

endinterface

// File: rtl/dcram_fill_seq.sv
// Line-fill sequencer: tracks the burst, counts beats and generates the
// RAM row address of the beat currently on fill_data.
module dcram_fill_seq
  import dcram_arb_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int LINE_BEATS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic              fill_valid,
  output logic              beat_wr,
  output logic [ADDR_W-1:0] beat_addr,
  output logic              fill_busy,
  output logic              fill_done
);

  localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  fill_state_e       state;
  logic [ADDR_W-1:0] base;
  logic [BEAT_W-1:0] beat;

  assign beat_wr   = (state == ST_FILL) && fill_valid;
  assign beat_addr = base + (ADDR_W'(beat) << 3);

  // busy/done are registered next to the state so the arbiter sees clean flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      base      <= '0;
      beat      <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          fill_done <= 1'b0;
          if (fill_start) begin
            state     <= ST_FILL;
            base      <= fill_addr;
            beat      <= '0;
            fill_busy <= 1'b1;
          end
        end
        ST_FILL: begin
          if (fill_valid) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              state     <= ST_DONE;
              fill_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          fill_busy <= 1'b0;
          fill_done <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          fill_busy <= 1'b0;
          fill_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dcram_arb.sv
// Data-cache RAM port arbiter: picks one of fill beat, store drain or
// pipeline read each cycle and registers the resulting RAM command.
module dcram_arb
  import dcram_arb_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int LINE_BEATS = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  dcram_arb_if.slave bus
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic              beat_wr;
  logic [ADDR_W-1:0] beat_addr;
  logic              fill_busy;
  logic              fill_done;

  logic [STARVE_W-1:0] starve;
  grant_src_e          src;
  logic                stb_ok;
  logic                bypass_hit;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        bank_q;
  logic [3:0]        we_q;
  logic [63:0]       data_q;
  logic              bypass_q;

  dcram_fill_seq #(
    .ADDR_W     (ADDR_W),
    .LINE_BEATS (LINE_BEATS)
  ) u_fill_seq (
    .clk        (clk),
    .reset      (reset),
    .fill_start (bus.fill_start),
    .fill_addr  (bus.fill_addr),
    .fill_valid (bus.fill_valid),
    .beat_wr    (beat_wr),
    .beat_addr  (beat_addr),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done)
  );

  // Stores stay out for the whole fill so no store can land inside the line being filled.
  always_comb begin
    stb_ok     = bus.stb_req && !fill_busy;
    bypass_hit = beat_wr && bus.pipe_req &&
                 (bus.pipe_addr[ADDR_W-1:3] == beat_addr[ADDR_W-1:3]);
    src        = SRC_NONE;
    if (beat_wr)
      src = SRC_FILL;
    else if (stb_ok && (starve == STARVE_LIM))
      src = SRC_STB;
    else if (bus.pipe_req)
      src = SRC_PIPE;
    else if (stb_ok)
      src = SRC_STB;
  end

  assign bus.pipe_gnt  = (src == SRC_PIPE) || bypass_hit;
  assign bus.stb_gnt   = (src == SRC_STB);
  assign bus.fill_busy = fill_busy;
  assign bus.fill_done = fill_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      bank_q   <= BANK_NONE;
      we_q     <= '0;
      data_q   <= '0;
      bypass_q <= 1'b0;
    end else begin
      case (src)
        SRC_FILL: begin
          addr_q   <= beat_addr;
          bank_q   <= BANK_BOTH;
          we_q     <= 4'b1111;
          data_q   <= bus.fill_data;
          bypass_q <= bypass_hit;
        end
        SRC_STB: begin
          addr_q   <= bus.stb_addr;
          bank_q   <= store_bank(bus.stb_addr[2]);
          we_q     <= bus.stb_be;
          data_q   <= {bus.stb_data, bus.stb_data};
          bypass_q <= 1'b0;
        end
        SRC_PIPE: begin
          addr_q   <= bus.pipe_addr;
          bank_q   <= BANK_BOTH;
          we_q     <= 4'b0000;
          bypass_q <= 1'b0;
        end
        default: begin
          bank_q   <= BANK_NONE;
          we_q     <= 4'b0000;
          bypass_q <= 1'b0;
        end
      endcase
    end
  end

  // Starvation count freezes during a fill since stores cannot be served then anyway.
  always_ff @(posedge clk) begin
    if (reset)
      starve <= '0;
    else if (!fill_busy) begin
      if (src == SRC_STB)
        starve <= '0;
      else if (bus.stb_req && (starve != STARVE_LIM))
        starve <= starve + 1'b1;
    end
  end

  assign bus.dc_addr     = addr_q;
  assign bus.dc_bank_sel = bank_q;
  assign bus.dc_we       = we_q;
  assign bus.dc_data     = data_q;
  assign bus.dc_bypass   = bypass_q;

endmodule
